// File: rtl/rad2_seq_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rad2_seq_div : sequential signed radix-2 restoring divider (/ and %)        |
// | Optional remainder output enabled by the DIV_REMAINDER_EN macro.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rad2_seq_div #(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start_i,
  input  logic [DATA_WIDTH_1-1:0] x1_i,
  input  logic [DATA_WIDTH_2-1:0] x2_i,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [DATA_WIDTH_1-1:0] q_o,
  output logic [DATA_WIDTH_2-1:0] r_o,
  output logic                    div0_o,
  output logic                    ovf_o
);

  localparam int                    CNT_W     = $clog2(DATA_WIDTH_1 + 1);
  localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(DATA_WIDTH_1 - 1);
  localparam logic [DATA_WIDTH_1-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH_1-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;

  logic                    s1, s2, div0, ovf;
  logic [DATA_WIDTH_1-1:0] dvd;
  logic [DATA_WIDTH_2-1:0] dsr;
  logic [DATA_WIDTH_2:0]   rem;
  logic [CNT_W-1:0]        cnt;

  logic [DATA_WIDTH_1-1:0] x1_mag, q_res;
  logic [DATA_WIDTH_2-1:0] x2_mag, r_res;
  logic [DATA_WIDTH_2+1:0] shifted, diff;
  logic                    q_bit;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = (x2_i == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (cnt == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        busy_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign x1_mag = x1_i[DATA_WIDTH_1-1] ? -x1_i : x1_i;
  assign x2_mag = x2_i[DATA_WIDTH_2-1] ? -x2_i : x2_i;

  // One restoring step: the extra top bit of diff is the borrow.
  assign shifted = {rem, dvd[DATA_WIDTH_1-1]};
  assign diff    = shifted - {2'b00, dsr};
  assign q_bit   = ~diff[DATA_WIDTH_2+1];

  assign q_res = (s1 ^ s2) ? -dvd : dvd;

`ifdef DIV_REMAINDER_EN
  logic [DATA_WIDTH_2-1:0] rem_mag, rem_signed, x1_ext;
  assign rem_mag    = rem[DATA_WIDTH_2-1:0];
  assign rem_signed = s1 ? -rem_mag : rem_mag;
  // On divide-by-zero the raw dividend is parked in dvd and passed through.
  assign x1_ext     = DATA_WIDTH_2'($signed(dvd));
  assign r_res      = div0 ? x1_ext : rem_signed;
`else
  assign r_res      = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
      q_o     <= '0;
      r_o     <= '0;
      div0_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        s1   <= x1_i[DATA_WIDTH_1-1];
        s2   <= x2_i[DATA_WIDTH_2-1];
        div0 <= (x2_i == '0);
        ovf  <= (x1_i == MOST_NEG) && (x2_i == '1);
        dvd  <= (x2_i == '0) ? x1_i : x1_mag;
        dsr  <= x2_mag;
        rem  <= '0;
        cnt  <= '0;
      end else if (state == CALC) begin
        rem <= q_bit ? diff[DATA_WIDTH_2:0] : shifted[DATA_WIDTH_2:0];
        dvd <= {dvd[DATA_WIDTH_1-2:0], q_bit};
        cnt <= cnt + CNT_W'(1);
      end else if (state == DONE) begin
        valid_o <= 1'b1;
        q_o     <= div0 ? '1 : q_res;
        r_o     <= r_res;
        div0_o  <= div0;
        ovf_o   <= ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rad2_seq_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rad2_seq_div : self-checking bench for rad2_seq_div                      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rad2_seq_div;

  localparam int DW1 = 8;
  localparam int DW2 = 8;

  logic           clk = 1'b0;
  logic           resetn;
  logic           start_i;
  logic [DW1-1:0] x1_i;
  logic [DW2-1:0] x2_i;
  logic           busy_o, valid_o, div0_o, ovf_o;
  logic [DW1-1:0] q_o;
  logic [DW2-1:0] r_o;

  int checks   = 0;
  int failures = 0;

  rad2_seq_div #(.DATA_WIDTH_1(DW1), .DATA_WIDTH_2(DW2)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start_i),
    .x1_i    (x1_i),
    .x2_i    (x2_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .q_o     (q_o),
    .r_o     (r_o),
    .div0_o  (div0_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy_o,  0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_q"},     q_o,     0);
    check({tag, "_r"},     r_o,     0);
    check({tag, "_div0"},  div0_o,  0);
    check({tag, "_ovf"},   ovf_o,   0);
  endtask

  // Reference: plain integer / and % with the two special cases.
  task automatic model(input logic [DW1-1:0] a, input logic [DW2-1:0] b,
                       output logic [DW1-1:0] eq, output logic [DW2-1:0] er,
                       output logic ed, output logic eo, output int elat);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    ed = 1'b0;
    eo = 1'b0;
    elat = DW1 + 1;
    if (sb == 0) begin
      eq = '1;
      er = DW2'(sa);
      ed = 1'b1;
      elat = 1;
    end else if (sa == -(2 ** (DW1 - 1)) && sb == -1) begin
      eq = DW1'(2 ** (DW1 - 1));
      er = '0;
      eo = 1'b1;
    end else begin
      eq = DW1'(sa / sb);
      er = DW2'(sa % sb);
    end
`ifndef DIV_REMAINDER_EN
    er = '0;
`endif
  endtask

  // disturb: 1 = second start with new operands at edge k+3 (must be ignored)
  task automatic run_op(input logic [DW1-1:0] a, input logic [DW2-1:0] b, input int disturb);
    logic [DW1-1:0] eq;
    logic [DW2-1:0] er;
    logic ed, eo;
    int elat, lat;
    model(a, b, eq, er, ed, eo, elat);
    @(negedge clk);
    x1_i = a; x2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    x1_i = DW1'($urandom);
    x2_i = DW2'($urandom);
    check("busy_after_accept", busy_o, 1);
    check("valid_after_accept", valid_o, 0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (disturb == 1 && n == 3) begin
        start_i = 1'b1;
        x1_i = 8'h10;
        x2_i = 8'h03;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      if (valid_o) begin
        lat = n;
        break;
      end
    end
    check("latency", lat, elat);
    if (lat != 0) begin
      check("q", q_o, eq);
      check("r", r_o, er);
      check("div0", div0_o, ed);
      check("ovf", ovf_o, eo);
      check("busy_at_result", busy_o, 0);
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; } op_t;
  op_t dir[$];

  initial begin
    int vcount;
    resetn  = 1'b0;
    start_i = 1'b1;
    x1_i    = 8'h64;
    x2_i    = 8'h07;
    repeat (5) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    @(negedge clk);
    start_i = 1'b0;
    resetn  = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    dir = '{'{8'h64, 8'h07}, '{8'hF0, 8'h03}, '{8'h81, 8'h81}, '{8'h7F, 8'hF0},
            '{8'h80, 8'hFF}, '{8'h80, 8'h01}, '{8'h2A, 8'h00}, '{8'hD6, 8'h00},
            '{8'h00, 8'h05}, '{8'h05, 8'h7F}, '{8'h80, 8'h80}, '{8'h7F, 8'h01}};
    foreach (dir[i]) run_op(dir[i].a, dir[i].b, 0);

    run_op(8'h64, 8'h07, 1);

    // Reset in the middle of an operation: no result may follow.
    @(negedge clk);
    x1_i = 8'h64; x2_i = 8'h07; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    resetn = 1'b1;
    vcount = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (valid_o) vcount++;
    end
    check("no_valid_after_abort", vcount, 0);
    run_op(8'hF0, 8'h03, 0);

    for (int i = 0; i < 80; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 7))
        0: b = 8'h00;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = 8'($urandom_range(1, 4));
        3: b = 8'hFF;
        default: ;
      endcase
      run_op(a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
